// File: rtl/lock_rst_seq_pkg.sv
// Shared types and constants for the PLL-lock reset sequencer and its helpers.
package lock_rst_seq_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LOSS_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/lock_rst_seq_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; shared by clock-crossing blocks.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], D};
        end
    end

    assign Q = chain_q[STAGES-1];

endmodule

// File: rtl/lock_rst_seq.sv
// Holds downstream logic in reset until PLL lock has been stable for a filter window,
// then for a hold window; counts lock losses seen while running.
module lock_rst_seq
    import lock_rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOCK,
    input  logic              SOFT_RST_REQ,
    output logic              SYS_RESET,
    output logic              READY,
    output logic [LOSS_W-1:0] LOSS_CNT
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic              lock_s;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              sys_reset_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (LOCK),
        .Q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = FILTER;
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // Lock loss wins over hold completion.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = sat_inc(loss_q);
                end else if (SOFT_RST_REQ) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            loss_q      <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            sys_reset_q <= (state_d != RUN);
        end
    end

    assign SYS_RESET = sys_reset_q;
    assign READY     = (state_q == RUN);
    assign LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_lock_rst_seq.sv
// Self-checking bench for lock_rst_seq: directed vector table, hand sequences and a
// randomized run compared against a countdown reference model.
module tb_lock_rst_seq;

    localparam int unsigned S = 2;
    localparam int unsigned F = 16;
    localparam int unsigned H = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       req = 1'b0;
    logic       sys_reset;
    logic       ready;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    lock_rst_seq #(
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F),
        .HOLD_CYCLES   (H)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .LOCK         (lock),
        .SOFT_RST_REQ (req),
        .SYS_RESET    (sys_reset),
        .READY        (ready),
        .LOSS_CNT     (loss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: LOCK delayed S edges, and a count of edges still needed before running.
    logic       m_pipe[$];
    int         m_rem;   // -1: idle, waiting for synchronized lock
    bit         m_run;
    logic [7:0] m_loss;

    function automatic void model_reset();
        m_pipe.delete();
        for (int i = 0; i < int'(S); i++) m_pipe.push_back(1'b0);
        m_rem  = -1;
        m_run  = 1'b0;
        m_loss = 8'd0;
    endfunction

    function automatic void model_edge(input logic l, input logic r, input logic s);
        logic ls;
        if (s) begin
            model_reset();
            return;
        end
        ls = m_pipe.pop_front();
        m_pipe.push_back(l);
        if (m_run) begin
            if (!ls) begin
                m_run = 1'b0;
                m_rem = -1;
                if (m_loss != 8'd255) m_loss = m_loss + 8'd1;
            end else if (r) begin
                m_run = 1'b0;
                m_rem = int'(H);
            end
        end else if (!ls) begin
            m_rem = -1;
        end else begin
            if (m_rem < 0) m_rem = 1 + int'(F) + int'(H);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_run = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic e_sys, input logic e_rdy,
                       input logic [7:0] e_loss);
        n_checks++;
        if ({sys_reset, ready, loss_cnt} === {e_sys, e_rdy, e_loss}) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got sys_reset=%b ready=%b loss_cnt=%0d, expected sys_reset=%b ready=%b loss_cnt=%0d",
                     name, $time, sys_reset, ready, loss_cnt, e_sys, e_rdy, e_loss);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
    task automatic cycle(input logic l, input logic r, input logic s);
        lock = l;
        req  = r;
        rst  = s;
        @(posedge clk);
        model_edge(l, r, s);
        @(negedge clk);
        chk("model", ~m_run, m_run, m_loss);
    endtask

    typedef struct {
        string      name;
        logic       lock;
        logic       req;
        logic       rst;
        int         n;
        logic       e_sys;
        logic       e_rdy;
        logic [7:0] e_loss;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();
        // Expectations hand-derived for S=2, F=16, H=64: RUN begins 83 edges after LOCK rises.
        tbl.push_back('{"reset",           0, 0, 1,  4, 1, 0, 8'd0});
        tbl.push_back('{"lock_pre_ready",  1, 0, 0, 82, 1, 0, 8'd0});
        tbl.push_back('{"lock_ready",      1, 0, 0,  1, 0, 1, 8'd0});
        tbl.push_back('{"drop_in_sync",    0, 0, 0,  1, 0, 1, 8'd0});
        tbl.push_back('{"drop_seen",       1, 0, 0,  2, 1, 0, 8'd1});
        tbl.push_back('{"relock_pre",      1, 0, 0, 80, 1, 0, 8'd1});
        tbl.push_back('{"relock_ready",    1, 0, 0,  1, 0, 1, 8'd1});
        tbl.push_back('{"soft_req",        1, 1, 0,  1, 1, 0, 8'd1});
        tbl.push_back('{"soft_hold",       1, 1, 0, 63, 1, 0, 8'd1});
        tbl.push_back('{"soft_done",       1, 0, 0,  1, 0, 1, 8'd1});
        tbl.push_back('{"loss_req_pre",    0, 0, 0,  2, 0, 1, 8'd1});
        tbl.push_back('{"loss_with_req",   0, 1, 0,  1, 1, 0, 8'd2});
        tbl.push_back('{"after_loss_pre",  1, 0, 0, 82, 1, 0, 8'd2});
        tbl.push_back('{"after_loss_rdy",  1, 0, 0,  1, 0, 1, 8'd2});
        tbl.push_back('{"reset_run",       1, 0, 1,  1, 1, 0, 8'd0});
        tbl.push_back('{"reset_hold",      0, 0, 1,  3, 1, 0, 8'd0});
        tbl.push_back('{"glitch_high",     1, 1, 0, 10, 1, 0, 8'd0});
        tbl.push_back('{"glitch_low",      0, 0, 0,  3, 1, 0, 8'd0});
        tbl.push_back('{"glitch_pre",      1, 0, 0, 82, 1, 0, 8'd0});
        tbl.push_back('{"glitch_ready",    1, 0, 0,  1, 0, 1, 8'd0});

        @(negedge clk);
        foreach (tbl[i]) begin
            repeat (tbl[i].n) cycle(tbl[i].lock, tbl[i].req, tbl[i].rst);
            chk(tbl[i].name, tbl[i].e_sys, tbl[i].e_rdy, tbl[i].e_loss);
        end

        // 260 lock-loss events from RUN; the counter must saturate at 255.
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        repeat (83) cycle(1'b1, 1'b0, 1'b0);
        chk("sat_first_run", 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 260; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            repeat (83) cycle(1'b1, 1'b0, 1'b0);
        end
        chk("loss_saturated", 1'b0, 1'b1, 8'd255);

        // Reset while in HOLD clears everything.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        chk("in_hold", 1'b1, 1'b0, 8'd255);
        cycle(1'b1, 1'b0, 1'b1);
        chk("reset_in_hold", 1'b1, 1'b0, 8'd0);

        // Randomized: slow-wandering LOCK with short glitches, sporadic requests and resets.
        begin
            logic l;
            logic r;
            logic s;
            l = 1'b1;
            for (int i = 0; i < 8000; i++) begin
                if ($urandom_range(0, 119) == 0) l = ~l;
                r = ($urandom_range(0, 29) == 0);
                s = ($urandom_range(0, 1999) == 0);
                if (l && $urandom_range(0, 299) == 0) cycle(1'b0, r, s);
                else cycle(l, r, s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
